// File: rtl/mod_n_updown_counter_pkg.sv
// Shared constants and helpers for the modulo-N up/down counter.
package mod_n_updown_counter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DN    = 1'b0;

endpackage

// File: rtl/tick_prescaler.sv
// Clock-enable prescaler: one tick every PRESCALE enabled cycles.
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    if (PRESCALE == 1) begin : g_bypass
        logic unused_in;
        assign unused_in = ^{clk, rst, clr};
        assign tick = en;
    end else begin : g_div
        localparam int PW = $clog2(PRESCALE);

        logic [PW-1:0] pre_q;
        logic [PW-1:0] pre_d;

        // Phase 0 reloads to PRESCALE-1; tick fires as the phase returns to 0.
        always_comb begin
            pre_d = pre_q;
            if (en) begin
                if (pre_q == '0) pre_d = PW'(PRESCALE - 1);
                else             pre_d = pre_q - PW'(1);
            end
        end

        assign tick = en && (pre_q == PW'(1));

        always_ff @(posedge clk or posedge rst) begin
            if (rst)      pre_q <= '0;
            else if (clr) pre_q <= '0;
            else          pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with runtime modulus, load, clear,
// wrap/saturate mode and a clock-enable prescaler.
module mod_n_updown_counter
    import mod_n_updown_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_dn,
    input  logic             mode,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             at_limit,
    output logic             ovf_sticky
);

    logic             tick;
    logic             step;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    tick_prescaler #(.PRESCALE(PRESCALE)) u_pre (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (clr | load),
        .tick (tick)
    );

    assign step = en & tick;

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_val > modulus) ? modulus : load_val;
        end else if (step) begin
            if (up_dn == DIR_UP) begin
                if (count_q < modulus) begin
                    count_d = count_q + WIDTH'(1);
                end else begin
                    count_d = (mode == MODE_SAT) ? modulus : '0;
                    tc_d    = 1'b1;
                end
            end else begin
                // A count stranded above a lowered modulus snaps down to it.
                if (count_q > modulus) begin
                    count_d = modulus;
                end else if (count_q != '0) begin
                    count_d = count_q - WIDTH'(1);
                end else begin
                    count_d = (mode == MODE_SAT) ? '0 : modulus;
                    tc_d    = 1'b1;
                end
            end
        end
        ovf_d = clr ? 1'b0 : (ovf_q | tc_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count      = count_q;
    assign tc         = tc_q;
    assign ovf_sticky = ovf_q;
    assign at_limit   = (up_dn == DIR_UP) ? (count_q == modulus)
                                          : (count_q == '0);

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Directed and randomized checks of mod_n_updown_counter against
// an arithmetic reference model, for PRESCALE=1 and PRESCALE=4.
module tb_mod_n_updown_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst, en, clr, load, up_dn, mode;
    logic [W-1:0] load_val, modulus;
    logic [W-1:0] count1, count4;
    logic         tc1, tc4, al1, al4, ovf1, ovf4;

    int n_cmp = 0;
    int n_bad = 0;

    int ps[2] = '{1, 4};
    int m_cnt[2];
    int m_ph[2];
    int m_tc[2];
    int m_ovf[2];

    always #5 clk = ~clk;

    mod_n_updown_counter #(.WIDTH(W), .PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load),
        .load_val(load_val), .up_dn(up_dn), .mode(mode),
        .modulus(modulus), .count(count1), .tc(tc1),
        .at_limit(al1), .ovf_sticky(ovf1)
    );

    mod_n_updown_counter #(.WIDTH(W), .PRESCALE(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load),
        .load_val(load_val), .up_dn(up_dn), .mode(mode),
        .modulus(modulus), .count(count4), .tc(tc4),
        .at_limit(al4), .ovf_sticky(ovf4)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_ph[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
        end
    endtask

    // One clock edge of the counter, written from the behavioural rules.
    task automatic model_edge();
        int md, lv;
        bit tk;
        md = int'(modulus);
        lv = int'(load_val);
        for (int i = 0; i < 2; i++) begin
            m_tc[i] = 0;
            if (clr) begin
                m_cnt[i] = 0; m_ph[i] = 0; m_ovf[i] = 0;
            end else if (load) begin
                m_cnt[i] = (lv > md) ? md : lv;
                m_ph[i]  = 0;
            end else if (en) begin
                tk = ((m_ph[i] % ps[i]) == ps[i] - 1);
                m_ph[i] = (m_ph[i] + 1) % ps[i];
                if (tk) begin
                    if (up_dn) begin
                        if (m_cnt[i] < md) m_cnt[i]++;
                        else begin
                            m_cnt[i] = mode ? md : 0;
                            m_tc[i] = 1;
                        end
                    end else begin
                        if (m_cnt[i] > md) m_cnt[i] = md;
                        else if (m_cnt[i] > 0) m_cnt[i]--;
                        else begin
                            m_cnt[i] = mode ? 0 : md;
                            m_tc[i] = 1;
                        end
                    end
                end
            end
            if (m_tc[i] != 0) m_ovf[i] = 1;
        end
    endtask

    function automatic int lim(input int c);
        return up_dn ? int'(c == int'(modulus)) : int'(c == 0);
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".cnt1"}, int'(count1), m_cnt[0]);
        chk({tag, ".tc1"},  int'(tc1),    m_tc[0]);
        chk({tag, ".lim1"}, int'(al1),    lim(m_cnt[0]));
        chk({tag, ".ovf1"}, int'(ovf1),   m_ovf[0]);
        chk({tag, ".cnt4"}, int'(count4), m_cnt[1]);
        chk({tag, ".tc4"},  int'(tc4),    m_tc[1]);
        chk({tag, ".lim4"}, int'(al4),    lim(m_cnt[1]));
        chk({tag, ".ovf4"}, int'(ovf4),   m_ovf[1]);
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        en = 0; clr = 0; load = 0;
    endtask

    initial begin
        int exp1[6] = '{1, 2, 3, 0, 1, 2};
        rst = 1; idle(); load_val = 0; up_dn = 1; mode = 0; modulus = 3;
        model_reset();
        #12;
        check_all("reset");
        rst = 0;

        // 1: mod-4 up wrap
        en = 1;
        for (int i = 0; i < 6; i++) begin
            cyc("t1");
            chk("t1.seq", int'(count1), exp1[i]);
            chk("t1.tc", int'(tc1), int'(exp1[i] == 0));
        end
        chk("t1.ovf", int'(ovf1), 1);

        // 2: mod-10 down wrap from 1, then saturate at 0
        modulus = 9; up_dn = 0; load = 1; load_val = 1;
        cyc("t2.ld");
        load = 0;
        for (int i = 0; i < 3; i++) cyc("t2.dn");
        chk("t2.at8", int'(count1), 8);
        load = 1; load_val = 0;
        cyc("t2.ld0");
        load = 0; mode = 1;
        for (int i = 0; i < 3; i++) begin
            cyc("t2.sat");
            chk("t2.sat.tc", int'(tc1), 1);
        end

        // 3: clamped load, then clear beats load
        en = 0; mode = 0; load = 1; load_val = 12;
        cyc("t3.clamp");
        chk("t3.clamp9", int'(count1), 9);
        clr = 1;
        cyc("t3.clr");
        chk("t3.clr0", int'(count1), 0);
        chk("t3.ovf0", int'(ovf1), 0);
        idle();

        // 4: modulus lowered below count
        for (int k = 0; k < 3; k++) begin
            modulus = 9; load = 1; load_val = 7;
            cyc("t4.ld");
            load = 0; en = 1; modulus = 5;
            mode = (k == 1); up_dn = (k != 2);
            cyc("t4.step");
            chk("t4.cnt", int'(count1), (k == 0) ? 0 : 5);
            chk("t4.tc", int'(tc1), int'(k != 2));
            en = 0;
        end

        // 5: prescaler divides by 4 and freezes phase while en low
        clr = 1;
        cyc("t5.clr");
        clr = 0; modulus = 15; up_dn = 1; mode = 0; en = 1;
        for (int i = 0; i < 8; i++) cyc("t5.run");
        chk("t5.two", int'(count4), 2);
        en = 0;
        for (int i = 0; i < 2; i++) cyc("t5.hold");
        en = 1;
        for (int i = 0; i < 3; i++) cyc("t5.pre");
        chk("t5.stall", int'(count4), 2);
        cyc("t5.tick");
        chk("t5.three", int'(count4), 3);

        // 6: async reset between edges
        idle(); modulus = 9; load = 1; load_val = 9;
        cyc("t6.ld9");
        load = 0; en = 1;
        cyc("t6.wrap");
        load = 1; load_val = 5; en = 0;
        cyc("t6.ld5");
        load = 0; en = 1;
        cyc("t6.six");
        chk("t6.six.cnt", int'(count1), 6);
        chk("t6.six.ovf", int'(ovf1), 1);
        #2 rst = 1;
        #1;
        model_reset();
        check_all("t6.rst");
        #1 rst = 0;
        cyc("t6.resume");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            en    = ($urandom_range(0, 3) != 0);
            clr   = ($urandom_range(0, 31) == 0);
            load  = ($urandom_range(0, 15) == 0);
            load_val = W'($urandom_range(0, 15));
            up_dn = W'($urandom_range(0, 1)) != 0;
            mode  = ($urandom_range(0, 7) == 0) ? ~mode : mode;
            if ($urandom_range(0, 15) == 0)
                modulus = W'($urandom_range(0, 15));
            cyc("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
